// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch sequencer, PC owner and IF/ID pipeline register
module fetch_stage #(
    parameter int                 PC_W     = 16,
    parameter int                 INST_W   = 16,
    parameter logic [PC_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stallF,
    input  logic              stallD,
    input  logic              InstBranch,
    input  logic [PC_W-1:0]   branchAddr,
    output logic              imemReq,
    output logic [PC_W-1:0]   imemAddr,
    input  logic              imemAck,
    input  logic [INST_W-1:0] imemData,
    output logic [INST_W-1:0] instD,
    output logic [PC_W-1:0]   pcPlus1D,
    output logic              validD
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]        r_state;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   r_drain_addr;
    logic [INST_W-1:0] r_buf;
    logic [PC_W-1:0]   r_buf_pc;
    logic [INST_W-1:0] r_inst_d;
    logic [PC_W-1:0]   r_pc_plus1_d;
    logic              r_valid_d;

    logic              w_stall;
    logic [PC_W-1:0]   w_pc_inc;

    assign w_stall  = stallF | stallD;
    assign w_pc_inc = r_pc + {{(PC_W-1){1'b0}}, 1'b1};

    // Request outputs come from registered state only; no path from imemAck.
    assign imemReq  = (r_state == ST_REQ) || (r_state == ST_DRAIN);
    assign imemAddr = (r_state == ST_DRAIN) ? r_drain_addr : r_pc;

    assign instD    = r_inst_d;
    assign pcPlus1D = r_pc_plus1_d;
    assign validD   = r_valid_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_PC;
            r_drain_addr <= RESET_PC;
            r_buf        <= '0;
            r_buf_pc     <= '0;
            r_inst_d     <= '0;
            r_pc_plus1_d <= '0;
            r_valid_d    <= 1'b0;
        end else if (InstBranch) begin
            // Redirect wins over everything, including a decode stall.
            r_inst_d     <= '0;
            r_pc_plus1_d <= '0;
            r_valid_d    <= 1'b0;
            r_pc         <= branchAddr;
            case (r_state)
                ST_REQ: begin
                    if (imemAck) begin
                        r_state <= ST_REQ;
                    end else begin
                        r_drain_addr <= r_pc;
                        r_state      <= ST_DRAIN;
                    end
                end
                ST_DRAIN: r_state <= imemAck ? ST_REQ : ST_DRAIN;
                default:  r_state <= ST_REQ;
            endcase
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ST_REQ;
                ST_REQ: begin
                    if (imemAck) begin
                        r_pc <= w_pc_inc;
                        if (!w_stall) begin
                            r_inst_d     <= imemData;
                            r_pc_plus1_d <= w_pc_inc;
                            r_valid_d    <= 1'b1;
                        end else begin
                            r_buf    <= imemData;
                            r_buf_pc <= w_pc_inc;
                            r_state  <= ST_HOLD;
                        end
                    end else if (!stallD) begin
                        r_inst_d     <= '0;
                        r_pc_plus1_d <= '0;
                        r_valid_d    <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!w_stall) begin
                        r_inst_d     <= r_buf;
                        r_pc_plus1_d <= r_buf_pc;
                        r_valid_d    <= 1'b1;
                        r_state      <= ST_REQ;
                    end
                end
                default: begin
                    // Stale data from the pre-redirect request is dropped.
                    r_inst_d     <= '0;
                    r_pc_plus1_d <= '0;
                    r_valid_d    <= 1'b0;
                    if (imemAck) begin
                        r_state <= ST_REQ;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk;
    logic        reset_n;
    logic        stallF;
    logic        stallD;
    logic        InstBranch;
    logic [15:0] branchAddr;
    logic        imemReq;
    logic [15:0] imemAddr;
    logic        imemAck;
    logic [15:0] imemData;
    logic [15:0] instD;
    logic [15:0] pcPlus1D;
    logic        validD;

    int total;
    int bad;

    fetch_stage #(.PC_W(16), .INST_W(16), .RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .stallF     (stallF),
        .stallD     (stallD),
        .InstBranch (InstBranch),
        .branchAddr (branchAddr),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemAck    (imemAck),
        .imemData   (imemData),
        .instD      (instD),
        .pcPlus1D   (pcPlus1D),
        .validD     (validD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [15:0] inst, input logic [15:0] pcp1, input logic vld);
        chk({tag, "_inst"}, {16'h0, instD}, {16'h0, inst});
        chk({tag, "_pcp1"}, {16'h0, pcPlus1D}, {16'h0, pcp1});
        chk({tag, "_valid"}, {31'h0, validD}, {31'h0, vld});
    endtask

    task automatic chk_req(input string tag, input logic req, input logic [15:0] addr);
        chk({tag, "_req"}, {31'h0, imemReq}, {31'h0, req});
        chk({tag, "_addr"}, {16'h0, imemAddr}, {16'h0, addr});
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset_n = 1'b0;
        stallF = 1'b0;
        stallD = 1'b0;
        InstBranch = 1'b0;
        branchAddr = 16'h0;
        imemAck = 1'b0;
        imemData = 16'h0;

        tick();
        tick();
        chk_req("rst", 1'b0, 16'h0000);
        chk_ifid("rst", 16'h0000, 16'h0000, 1'b0);

        reset_n = 1'b1;
        tick();
        chk_req("first_req", 1'b1, 16'h0000);

        // Zero-wait memory, data = addr ^ 0xA000
        imemAck = 1'b1;
        for (int a = 0; a < 4; a++) begin
            imemData = 16'(a) ^ 16'hA000;
            tick();
            chk_ifid("zw", 16'(a) ^ 16'hA000, 16'(a + 1), 1'b1);
            chk_req("zw", 1'b1, 16'(a + 1));
        end

        // Two wait states at address 4
        imemAck = 1'b0;
        tick();
        chk_ifid("wait1", 16'h0000, 16'h0000, 1'b0);
        chk_req("wait1", 1'b1, 16'h0004);
        tick();
        chk_ifid("wait2", 16'h0000, 16'h0000, 1'b0);
        chk_req("wait2", 1'b1, 16'h0004);
        imemAck = 1'b1;
        imemData = 16'hA004;
        tick();
        chk_ifid("wait_done", 16'hA004, 16'h0005, 1'b1);
        chk_req("wait_done", 1'b1, 16'h0005);

        // Stall arrives with the ack for address 5
        stallF = 1'b1;
        stallD = 1'b1;
        imemData = 16'hA005;
        tick();
        chk_ifid("hold1", 16'hA004, 16'h0005, 1'b1);
        chk_req("hold1", 1'b0, 16'h0006);
        imemAck = 1'b0;
        tick();
        chk_ifid("hold2", 16'hA004, 16'h0005, 1'b1);
        chk_req("hold2", 1'b0, 16'h0006);
        tick();
        chk_ifid("hold3", 16'hA004, 16'h0005, 1'b1);
        stallF = 1'b0;
        stallD = 1'b0;
        tick();
        chk_ifid("release", 16'hA005, 16'h0006, 1'b1);
        chk_req("release", 1'b1, 16'h0006);
        imemAck = 1'b1;
        imemData = 16'hA006;
        tick();
        chk_ifid("fetch6", 16'hA006, 16'h0007, 1'b1);
        chk_req("fetch6", 1'b1, 16'h0007);

        // Redirect while address 7 is outstanding
        imemAck = 1'b0;
        InstBranch = 1'b1;
        branchAddr = 16'h0040;
        tick();
        InstBranch = 1'b0;
        chk_ifid("drain1", 16'h0000, 16'h0000, 1'b0);
        chk_req("drain1", 1'b1, 16'h0007);
        tick();
        chk_req("drain2", 1'b1, 16'h0007);
        chk_ifid("drain2", 16'h0000, 16'h0000, 1'b0);
        imemAck = 1'b1;
        imemData = 16'hA007;
        tick();
        chk_ifid("drain_ack", 16'h0000, 16'h0000, 1'b0);
        chk_req("drain_ack", 1'b1, 16'h0040);
        imemData = 16'hA040;
        tick();
        chk_ifid("tgt40", 16'hA040, 16'h0041, 1'b1);
        chk_req("tgt40", 1'b1, 16'h0041);

        // Branch with stallD and ack together: bubble, not hold
        stallD = 1'b1;
        InstBranch = 1'b1;
        branchAddr = 16'h0080;
        imemData = 16'hA041;
        tick();
        chk_ifid("br_stall", 16'h0000, 16'h0000, 1'b0);
        chk_req("br_stall", 1'b1, 16'h0080);

        // Redirect to 0xFFFF and wrap
        stallD = 1'b0;
        branchAddr = 16'hFFFF;
        imemData = 16'hA080;
        tick();
        InstBranch = 1'b0;
        chk_ifid("br_ffff", 16'h0000, 16'h0000, 1'b0);
        chk_req("br_ffff", 1'b1, 16'hFFFF);
        imemData = 16'h5FFF;
        tick();
        chk_ifid("wrap", 16'h5FFF, 16'h0000, 1'b1);
        chk_req("wrap", 1'b1, 16'h0000);

        // Reset asserted mid-wait while decode holds IF/ID
        imemAck = 1'b0;
        stallD = 1'b1;
        tick();
        chk_ifid("pre_rst", 16'h5FFF, 16'h0000, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_req("async_rst", 1'b0, 16'h0000);
        chk_ifid("async_rst", 16'h0000, 16'h0000, 1'b0);
        stallD = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk_req("post_rst", 1'b1, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
